// File: rtl/move_sequencer.sv
// Move sequencer for a falling L-tromino on an 8x8 board.
// Buffers move/gravity requests as sticky pending flags, services them one
// at a time in priority order through a single-cycle collision check, and
// hands a blocked piece to the board owner through a LOCK/ack handshake.
module move_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       game_clk,
  input  logic       btn_right_en,
  input  logic       btn_left_en,
  input  logic       btn_rotate_en,
  input  logic       btn_down_en,
  input  logic [7:0] fallenBlocks [0:7],
  input  logic       lock_ack,
  output logic [2:0] cur_pos_x,
  output logic [2:0] cur_pos_y,
  output logic [1:0] cur_rot,
  output logic       lock_valid,
  output logic       game_over,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    LOCK  = 3'd4,
    OVER  = 3'd5
  } state_t;

  // Pending bit order doubles as priority order: bit 0 is serviced first.
  localparam int P_RIGHT  = 0;
  localparam int P_LEFT   = 1;
  localparam int P_ROTATE = 2;
  localparam int P_DOWN   = 3;

  state_t     state_reg, state_next;
  logic [2:0] cur_x_reg, cur_x_next;
  logic [2:0] cur_y_reg, cur_y_next;
  logic [1:0] cur_rot_reg, cur_rot_next;
  logic [4:0] pend_reg, pend_next;
  // Candidate coordinates are 4 bits wide so stepping off either edge shows
  // up as a value above 7 instead of wrapping back onto the board.
  logic [3:0] cand_x_reg, cand_x_next;
  logic [3:0] cand_y_reg, cand_y_next;
  logic [1:0] cand_rot_reg, cand_rot_next;
  logic       cand_fall_reg, cand_fall_next;

  logic [4:0] req;
  logic [4:0] clr;
  logic [3:0] cell_used;
  logic [3:0] cell_hit;
  logic       cand_hit;
  logic       spawn_hit;

  assign req = {game_clk, btn_down_en, btn_rotate_en, btn_left_en, btn_right_en};

  // Cells of the 2x2 box: 0=(x,y) 1=(x+1,y) 2=(x,y+1) 3=(x+1,y+1); each rotation drops one.
  always_comb begin
    cell_used = 4'b1111;
    case (cand_rot_reg)
      2'd0:    cell_used = 4'b1101;
      2'd1:    cell_used = 4'b0111;
      2'd2:    cell_used = 4'b1011;
      default: cell_used = 4'b1110;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cell
      logic [4:0] cell_x;
      logic [4:0] cell_y;
      assign cell_x = {1'b0, cand_x_reg} + 5'(gi % 2);
      assign cell_y = {1'b0, cand_y_reg} + 5'(gi / 2);
      assign cell_hit[gi] = cell_used[gi] &&
                            ((cell_x > 5'd7) || (cell_y > 5'd7) ||
                             fallenBlocks[cell_y[2:0]][cell_x[2:0]]);
    end
  endgenerate

  assign cand_hit = |cell_hit;
  // Spawn placement is fixed: rotation 0 at (3,0) occupies (3,0),(3,1),(4,1).
  assign spawn_hit = fallenBlocks[0][3] | fallenBlocks[1][3] | fallenBlocks[1][4];

  // Next-state, request bookkeeping and candidate selection.
  always_comb begin
    state_next     = state_reg;
    cur_x_next     = cur_x_reg;
    cur_y_next     = cur_y_reg;
    cur_rot_next   = cur_rot_reg;
    cand_x_next    = cand_x_reg;
    cand_y_next    = cand_y_reg;
    cand_rot_next  = cand_rot_reg;
    cand_fall_next = cand_fall_reg;
    clr            = 5'd0;
    pend_next      = pend_reg;

    if (state_reg == SPAWN || state_reg == WAIT || state_reg == CHECK) begin
      pend_next = pend_reg | req;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = SPAWN;
          cur_x_next   = 3'd3;
          cur_y_next   = 3'd0;
          cur_rot_next = 2'd0;
        end
      end
      SPAWN: begin
        state_next = spawn_hit ? OVER : WAIT;
      end
      WAIT: begin
        if (|pend_reg) begin
          state_next     = CHECK;
          cand_x_next    = {1'b0, cur_x_reg};
          cand_y_next    = {1'b0, cur_y_reg};
          cand_rot_next  = cur_rot_reg;
          cand_fall_next = 1'b0;
          if (pend_reg[P_RIGHT]) begin
            cand_x_next = {1'b0, cur_x_reg} + 4'd1;
            clr[P_RIGHT] = 1'b1;
          end else if (pend_reg[P_LEFT]) begin
            cand_x_next = {1'b0, cur_x_reg} - 4'd1;
            clr[P_LEFT] = 1'b1;
          end else if (pend_reg[P_ROTATE]) begin
            cand_rot_next = cur_rot_reg + 2'd1;
            clr[P_ROTATE] = 1'b1;
          end else if (pend_reg[P_DOWN]) begin
            cand_y_next    = {1'b0, cur_y_reg} + 4'd1;
            cand_fall_next = 1'b1;
            clr[P_DOWN]    = 1'b1;
          end else begin
            cand_y_next    = {1'b0, cur_y_reg} + 4'd1;
            cand_fall_next = 1'b1;
            clr[4]         = 1'b1;
          end
          pend_next = (pend_reg | req) & ~clr;
        end
      end
      CHECK: begin
        if (!cand_hit) begin
          cur_x_next   = cand_x_reg[2:0];
          cur_y_next   = cand_y_reg[2:0];
          cur_rot_next = cand_rot_reg;
          state_next   = WAIT;
        end else if (cand_fall_reg) begin
          state_next = LOCK;
          pend_next  = 5'd0;
        end else begin
          state_next = WAIT;
        end
      end
      LOCK: begin
        if (lock_ack) begin
          state_next   = SPAWN;
          cur_x_next   = 3'd3;
          cur_y_next   = 3'd0;
          cur_rot_next = 2'd0;
        end
      end
      default: begin
        state_next = OVER;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_x_reg     <= 3'd0;
      cur_y_reg     <= 3'd0;
      cur_rot_reg   <= 2'd0;
      pend_reg      <= 5'd0;
      cand_x_reg    <= 4'd0;
      cand_y_reg    <= 4'd0;
      cand_rot_reg  <= 2'd0;
      cand_fall_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_x_reg     <= cur_x_next;
      cur_y_reg     <= cur_y_next;
      cur_rot_reg   <= cur_rot_next;
      pend_reg      <= pend_next;
      cand_x_reg    <= cand_x_next;
      cand_y_reg    <= cand_y_next;
      cand_rot_reg  <= cand_rot_next;
      cand_fall_reg <= cand_fall_next;
    end
  end

  assign cur_pos_x  = cur_x_reg;
  assign cur_pos_y  = cur_y_reg;
  assign cur_rot    = cur_rot_reg;
  assign lock_valid = (state_reg == LOCK);
  assign game_over  = (state_reg == OVER);
  assign busy       = (state_reg == CHECK);

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: inputs change and outputs are sampled
// on the falling clock edge, well away from the active rising edge.
module tb_move_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       game_clk;
  logic       btn_right_en;
  logic       btn_left_en;
  logic       btn_rotate_en;
  logic       btn_down_en;
  logic [7:0] fb [0:7];
  logic       lock_ack;
  logic [2:0] cur_pos_x;
  logic [2:0] cur_pos_y;
  logic [1:0] cur_rot;
  logic       lock_valid;
  logic       game_over;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Request mask bits: 0 right, 1 left, 2 rotate, 3 down, 4 gravity.
  localparam logic [4:0] R_RIGHT = 5'b00001;
  localparam logic [4:0] R_LEFT  = 5'b00010;
  localparam logic [4:0] R_ROT   = 5'b00100;
  localparam logic [4:0] R_DOWN  = 5'b01000;
  localparam logic [4:0] R_GRAV  = 5'b10000;

  move_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .game_clk     (game_clk),
    .btn_right_en (btn_right_en),
    .btn_left_en  (btn_left_en),
    .btn_rotate_en(btn_rotate_en),
    .btn_down_en  (btn_down_en),
    .fallenBlocks (fb),
    .lock_ack     (lock_ack),
    .cur_pos_x    (cur_pos_x),
    .cur_pos_y    (cur_pos_y),
    .cur_rot      (cur_rot),
    .lock_valid   (lock_valid),
    .game_over    (game_over),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic set_req(input logic [4:0] r);
    btn_right_en  = r[0];
    btn_left_en   = r[1];
    btn_rotate_en = r[2];
    btn_down_en   = r[3];
    game_clk      = r[4];
  endtask

  // Called on a falling edge; holds the request across exactly one rising edge.
  task automatic pulse_req(input logic [4:0] r);
    set_req(r);
    @(negedge clk);
    set_req(5'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    lock_ack = 1'b1;
    @(negedge clk);
    lock_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int r);
    check_eq({tag, "_x"}, int'(cur_pos_x), x);
    check_eq({tag, "_y"}, int'(cur_pos_y), y);
    check_eq({tag, "_rot"}, int'(cur_rot), r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(1);
    rst = 1'b0;
    ticks(1);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 8; i++) fb[i] = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    lock_ack = 1'b0;
    set_req(5'd0);
    clear_board();
    ticks(2);

    // Reset state
    check_pos("rst", 0, 0, 0);
    check_eq("rst_lock", int'(lock_valid), 0);
    check_eq("rst_over", int'(game_over), 0);
    check_eq("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Nothing moves in IDLE
    pulse_req(R_RIGHT | R_DOWN | R_GRAV);
    pulse_ack();
    ticks(4);
    check_pos("idle", 0, 0, 0);
    check_eq("idle_busy", int'(busy), 0);

    // Spawn on an empty board
    pulse_start();
    check_pos("spawn", 3, 0, 0);
    ticks(1);
    check_eq("spawn_over", int'(game_over), 0);

    // Single right move: busy one cycle, x updates two edges after the pulse
    pulse_req(R_RIGHT);
    check_eq("r1_busy_n", int'(busy), 0);
    ticks(1);
    check_eq("r1_busy_n1", int'(busy), 1);
    check_eq("r1_x_n1", int'(cur_pos_x), 3);
    ticks(1);
    check_eq("r1_busy_n2", int'(busy), 0);
    check_pos("r1_n2", 4, 0, 0);

    // Walk to x=6, then bump the right wall
    pulse_req(R_RIGHT); ticks(3);
    pulse_req(R_RIGHT); ticks(3);
    check_eq("x6", int'(cur_pos_x), 6);
    pulse_req(R_RIGHT); ticks(3);
    check_eq("rwall_x", int'(cur_pos_x), 6);
    check_eq("rwall_lock", int'(lock_valid), 0);

    // lock_ack outside LOCK has no effect
    pulse_ack(); ticks(2);
    check_pos("ack_wait", 6, 0, 0);

    // Walk to x=0, then bump the left wall (no wrap to 7)
    for (int i = 0; i < 6; i++) begin
      pulse_req(R_LEFT); ticks(3);
    end
    check_eq("x0", int'(cur_pos_x), 0);
    pulse_req(R_LEFT); ticks(3);
    check_eq("lwall_x", int'(cur_pos_x), 0);
    check_eq("lwall_lock", int'(lock_valid), 0);

    // Simultaneous right + rotate + gravity serviced in priority order
    do_reset();
    check_pos("rst2", 0, 0, 0);
    pulse_start(); ticks(1);
    pulse_req(R_RIGHT | R_ROT | R_GRAV);
    ticks(2);
    check_pos("prio_1", 4, 0, 0);
    ticks(2);
    check_pos("prio_2", 4, 0, 1);
    ticks(2);
    check_pos("prio_3", 4, 1, 1);
    ticks(2);
    check_pos("prio_end", 4, 1, 1);

    // Down button moves one row
    pulse_req(R_DOWN); ticks(3);
    check_pos("down", 4, 2, 1);

    // Gravity onto a full row locks the piece in place
    do_reset();
    fb[2] = 8'hFF;
    pulse_start(); ticks(1);
    pulse_req(R_GRAV);
    ticks(1);
    check_eq("lk_busy", int'(busy), 1);
    ticks(1);
    check_eq("lk_lock", int'(lock_valid), 1);
    check_pos("lk", 3, 0, 0);
    pulse_req(R_LEFT); ticks(3);
    check_eq("lk_left_x", int'(cur_pos_x), 3);
    check_eq("lk_hold", int'(lock_valid), 1);
    pulse_ack();
    check_eq("ack_lock", int'(lock_valid), 0);
    check_pos("respawn", 3, 0, 0);
    ticks(5);
    check_pos("respawn_idle", 3, 0, 0);
    check_eq("respawn_over", int'(game_over), 0);

    // Asynchronous reset while in LOCK
    pulse_req(R_GRAV); ticks(2);
    check_eq("lk2_lock", int'(lock_valid), 1);
    rst = 1'b1;
    #1;
    check_eq("arst_lock", int'(lock_valid), 0);
    check_pos("arst", 0, 0, 0);
    check_eq("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    ticks(3);
    check_pos("arst_idle", 0, 0, 0);
    pulse_start();
    check_pos("arst_spawn", 3, 0, 0);
    ticks(1);
    check_eq("arst_over", int'(game_over), 0);

    // Spawn collision ends the game; only reset leaves OVER
    do_reset();
    clear_board();
    fb[0] = 8'h08;
    pulse_start();
    ticks(1);
    check_eq("go_over", int'(game_over), 1);
    check_pos("go", 3, 0, 0);
    fb[0] = 8'h00;
    pulse_start();
    pulse_req(R_RIGHT | R_DOWN | R_GRAV);
    pulse_ack();
    ticks(4);
    check_eq("go_hold", int'(game_over), 1);
    check_pos("go_frozen", 3, 0, 0);
    rst = 1'b1;
    #1;
    check_eq("go_rst", int'(game_over), 0);
    @(negedge clk);
    rst = 1'b0;
    ticks(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
